fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fq_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch queue
package fetch_pkg;

  localparam int              FQ_ADDR_W   = 16;
  localparam int              FQ_WORD_W   = 16;
  localparam int              FQ_DEPTH    = 4;
  localparam int              FQ_LEN_BIT  = 15;
  localparam logic [15:0]     FQ_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fq_state_e;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_WORD_W-1:0] ir;
    logic [FQ_WORD_W-1:0] k16;
    logic                 len2;
  } fq_entry_t;

  // Flattened entry width for non-default address/word widths.
  function automatic int fq_entry_w(input int aw, input int ww);
    return aw + 2 * ww + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory, redirect and decoder signals of the fetch queue
interface fetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_opc;
  logic [WORD_W-1:0] mem_arg;
  logic              redirect_w;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_pc;
  logic [WORD_W-1:0] dec_ir;
  logic [WORD_W-1:0] dec_k16;
  logic              dec_len2;

  modport master (
    output mem_req, mem_addr, dec_valid, dec_pc, dec_ir, dec_k16, dec_len2,
    input  mem_ack, mem_opc, mem_arg, redirect_w, redirect_pc, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, dec_valid, dec_pc, dec_ir, dec_k16, dec_len2,
    output mem_ack, mem_opc, mem_arg, redirect_w, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - synchronous entry FIFO with flush and combinational head
module fq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 49,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FSM, fetch PC and length predecode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FQ_ADDR_W,
  parameter int                WORD_W   = FQ_WORD_W,
  parameter int                DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC),
  parameter int                LEN_BIT  = FQ_LEN_BIT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int         EW       = fq_entry_w(ADDR_W, WORD_W);
  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [0:0] ST_FETCH = FETCH;
  localparam logic [0:0] ST_DRAIN = DRAIN;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] drain_addr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head_entry;
  logic [ADDR_W-1:0] fpc_step;
  logic              in_fetch;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              len2_in;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = bus.redirect_pc[0];

  assign in_fetch     = (state_q == ST_FETCH);
  assign bus.mem_req  = in_fetch ? (count < CW'(DEPTH)) : 1'b1;
  assign bus.mem_addr = in_fetch ? fpc : drain_addr;
  assign xfer         = bus.mem_req & bus.mem_ack;

  // A redirect wins over both ends of the queue: nothing from the old stream survives.
  assign push          = in_fetch & xfer & ~bus.redirect_w;
  assign bus.dec_valid = in_fetch & (count != '0);
  assign pop           = bus.dec_valid & bus.dec_ready & ~bus.redirect_w;

  assign len2_in    = bus.mem_opc[LEN_BIT];
  assign fpc_step   = len2_in ? ADDR_W'(4) : ADDR_W'(2);
  assign push_entry = {fpc, bus.mem_opc, bus.mem_arg, len2_in};

  assign {bus.dec_pc, bus.dec_ir, bus.dec_k16, bus.dec_len2} = head_entry;

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_w),
    .din   (push_entry),
    .head  (head_entry),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fpc        <= {RESET_PC[ADDR_W-1:1], 1'b0};
      drain_addr <= '0;
    end else begin
      if (bus.redirect_w) begin
        fpc <= {bus.redirect_pc[ADDR_W-1:1], 1'b0};
      end else if (push) begin
        fpc <= fpc + fpc_step;
      end

      // The abandoned request must still be completed at its original address.
      case (state_q)
        ST_FETCH: begin
          if (bus.redirect_w && bus.mem_req && !bus.mem_ack) begin
            state_q    <= ST_DRAIN;
            drain_addr <= fpc;
          end
        end
        default: begin
          if (bus.mem_ack) state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table-driven bench for fetch_queue
module tb_fetch_queue;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_queue_if #(.ADDR_W(16), .WORD_W(16)) bus ();

  fetch_queue #(
    .ADDR_W   (16),
    .WORD_W   (16),
    .DEPTH    (4),
    .RESET_PC (16'h0100),
    .LEN_BIT  (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [15:0] opc;
    logic [15:0] arg;
    logic        w;
    logic [15:0] rpc;
    logic        dr;
    logic        ereq;
    logic [15:0] eaddr;
    logic        edv;
    logic [15:0] epc;
    logic [15:0] eir;
    logic [15:0] ek16;
    logic        elen;
    logic        est;
  } vec_t;

  vec_t vt[29];

  function automatic vec_t mk(
    input logic r, input logic a, input logic [15:0] opc, input logic [15:0] arg,
    input logic w, input logic [15:0] rpc, input logic dr,
    input logic ereq, input logic [15:0] eaddr, input logic edv,
    input logic [15:0] epc, input logic [15:0] eir, input logic [15:0] ek16,
    input logic elen, input logic est);
    vec_t v;
    v.rst = r;   v.ack = a;    v.opc = opc;  v.arg = arg;
    v.w = w;     v.rpc = rpc;  v.dr = dr;
    v.ereq = ereq; v.eaddr = eaddr; v.edv = edv;
    v.epc = epc; v.eir = eir;  v.ek16 = ek16; v.elen = elen; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic [15:0] opc,
                      input logic [15:0] arg, input logic w, input logic [15:0] rpc,
                      input logic dr);
    @(negedge clk);
    rst             = r;
    bus.mem_ack     = a;
    bus.mem_opc     = opc;
    bus.mem_arg     = arg;
    bus.redirect_w  = w;
    bus.redirect_pc = rpc;
    bus.dec_ready   = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_opc = '0; bus.mem_arg = '0;
    bus.redirect_w = 1'b0; bus.redirect_pc = '0; bus.dec_ready = 1'b0;

    //        r a opc      arg      w rpc      dr  req addr     dv pc       ir       k16      l  st
    vt[0]  = mk(1,0,16'h0000,16'h0000,0,16'h0000,0, 1,16'h0100,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[1]  = mk(0,1,16'h0001,16'hA001,0,16'h0000,1, 1,16'h0102,1,16'h0100,16'h0001,16'hA001,0,0);
    vt[2]  = mk(0,1,16'h0002,16'hA002,0,16'h0000,1, 1,16'h0104,1,16'h0102,16'h0002,16'hA002,0,0);
    vt[3]  = mk(0,1,16'h8003,16'hA003,0,16'h0000,1, 1,16'h0108,1,16'h0104,16'h8003,16'hA003,1,0);
    vt[4]  = mk(0,1,16'h0004,16'hA004,0,16'h0000,1, 1,16'h010A,1,16'h0108,16'h0004,16'hA004,0,0);
    vt[5]  = mk(0,0,16'h0000,16'h0000,0,16'h0000,1, 1,16'h010A,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[6]  = mk(0,1,16'h0010,16'hB010,0,16'h0000,0, 1,16'h010C,1,16'h010A,16'h0010,16'hB010,0,0);
    vt[7]  = mk(0,1,16'h0011,16'hB011,0,16'h0000,0, 1,16'h010E,1,16'h010A,16'h0010,16'hB010,0,0);
    vt[8]  = mk(0,1,16'h0012,16'hB012,0,16'h0000,0, 1,16'h0110,1,16'h010A,16'h0010,16'hB010,0,0);
    vt[9]  = mk(0,1,16'h0013,16'hB013,0,16'h0000,0, 0,16'h0112,1,16'h010A,16'h0010,16'hB010,0,0);
    vt[10] = mk(0,1,16'h0014,16'hB014,0,16'h0000,0, 0,16'h0112,1,16'h010A,16'h0010,16'hB010,0,0);
    vt[11] = mk(0,0,16'h0000,16'h0000,0,16'h0000,1, 1,16'h0112,1,16'h010C,16'h0011,16'hB011,0,0);
    vt[12] = mk(0,1,16'h0020,16'hB020,1,16'h0400,1, 1,16'h0400,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[13] = mk(0,1,16'h0021,16'hB021,1,16'h0200,1, 1,16'h0200,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[14] = mk(0,0,16'h0000,16'h0000,0,16'h0000,1, 1,16'h0200,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[15] = mk(0,0,16'h0000,16'h0000,1,16'h0801,1, 1,16'h0200,0,16'h0000,16'h0000,16'h0000,0,1);
    vt[16] = mk(0,0,16'h0000,16'h0000,0,16'h0000,1, 1,16'h0200,0,16'h0000,16'h0000,16'h0000,0,1);
    vt[17] = mk(0,1,16'h0030,16'hC030,0,16'h0000,1, 1,16'h0800,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[18] = mk(0,1,16'h0031,16'h1234,0,16'h0000,0, 1,16'h0802,1,16'h0800,16'h0031,16'h1234,0,0);
    vt[19] = mk(0,1,16'h0000,16'h0000,1,16'hFFFE,1, 1,16'hFFFE,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[20] = mk(0,1,16'h0040,16'h0041,0,16'h0000,0, 1,16'h0000,1,16'hFFFE,16'h0040,16'h0041,0,0);
    vt[21] = mk(0,1,16'h0000,16'h0000,1,16'hFFFC,1, 1,16'hFFFC,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[22] = mk(0,1,16'h8042,16'hBEEF,0,16'h0000,0, 1,16'h0000,1,16'hFFFC,16'h8042,16'hBEEF,1,0);
    vt[23] = mk(0,0,16'h0000,16'h0000,1,16'h0300,1, 1,16'h0000,0,16'h0000,16'h0000,16'h0000,0,1);
    vt[24] = mk(0,0,16'h0000,16'h0000,1,16'h0500,1, 1,16'h0000,0,16'h0000,16'h0000,16'h0000,0,1);
    vt[25] = mk(0,1,16'h0000,16'h0000,0,16'h0000,1, 1,16'h0500,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[26] = mk(0,0,16'h0000,16'h0000,1,16'h0600,1, 1,16'h0500,0,16'h0000,16'h0000,16'h0000,0,1);
    vt[27] = mk(1,1,16'h0000,16'h0000,1,16'h0700,1, 1,16'h0100,0,16'h0000,16'h0000,16'h0000,0,0);
    vt[28] = mk(0,1,16'h0050,16'h0051,0,16'h0000,0, 1,16'h0102,1,16'h0100,16'h0050,16'h0051,0,0);

    for (int i = 0; i < 29; i++) begin
      step(vt[i].rst, vt[i].ack, vt[i].opc, vt[i].arg, vt[i].w, vt[i].rpc, vt[i].dr);
      chk($sformatf("v%0d_req", i),   32'(bus.mem_req),   32'(vt[i].ereq));
      chk($sformatf("v%0d_addr", i),  32'(bus.mem_addr),  32'(vt[i].eaddr));
      chk($sformatf("v%0d_dv", i),    32'(bus.dec_valid), 32'(vt[i].edv));
      chk($sformatf("v%0d_state", i), 32'(dut.state_q),   32'(vt[i].est));
      if (vt[i].edv) begin
        chk($sformatf("v%0d_pc", i),   32'(bus.dec_pc),   32'(vt[i].epc));
        chk($sformatf("v%0d_ir", i),   32'(bus.dec_ir),   32'(vt[i].eir));
        chk($sformatf("v%0d_k16", i),  32'(bus.dec_k16),  32'(vt[i].ek16));
        chk($sformatf("v%0d_len2", i), 32'(bus.dec_len2), 32'(vt[i].elen));
      end
    end

    // Simultaneous push and pop at count 3, then fill and release by one pop.
    step(0, 1, 16'h0060, 16'h0000, 0, 16'h0000, 0);
    step(0, 1, 16'h0061, 16'h0000, 0, 16'h0000, 0);
    chk("seq_count3", 32'(dut.u_fifo.count), 32'd3);
    step(0, 1, 16'h0062, 16'h0000, 0, 16'h0000, 1);
    chk("seq_pushpop_count", 32'(dut.u_fifo.count), 32'd3);
    chk("seq_pushpop_pc",    32'(bus.dec_pc),        32'h0102);
    chk("seq_pushpop_addr",  32'(bus.mem_addr),      32'h0108);
    step(0, 1, 16'h0063, 16'h0000, 0, 16'h0000, 0);
    chk("seq_full_req",   32'(bus.mem_req),       32'd0);
    chk("seq_full_count", 32'(dut.u_fifo.count),  32'd4);
    step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    bus.dec_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      if (bus.mem_req) seen = 1'b1;
      else step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    end
    chk("seq_release_req", 32'(seen),        32'd1);
    chk("seq_release_addr", 32'(bus.mem_addr), 32'h010A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
